// File: rtl/wb_port_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_port_arb
// Function : Four per-producer writeback FIFOs arbitrated with rotating
//            priority onto three register-file write ports, with no two
//            same-register writes issued in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [3:0]  req_valid,
    output logic [3:0]  req_ready,
    input  logic [11:0] req_waddr,
    input  logic [63:0] req_wdata,
    input  logic [23:0] req_wrob,
    output logic        wen0,
    output logic        wen1,
    output logic        wen2,
    output logic [2:0]  waddr0,
    output logic [2:0]  waddr1,
    output logic [2:0]  waddr2,
    output logic [15:0] wdata0,
    output logic [15:0] wdata1,
    output logic [15:0] wdata2,
    output logic [5:0]  wrob0,
    output logic [5:0]  wrob1,
    output logic [5:0]  wrob2
);

    localparam int             c_AW      = $clog2(DEPTH);
    localparam int             c_CW      = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL   = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT1   = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR1   = c_AW'(1);

    // Entry layout: {waddr[24:22], wdata[21:6], wrob[5:0]}
    logic [24:0]       r_mem   [4][DEPTH];
    logic [c_AW-1:0]   r_wptr  [4];
    logic [c_AW-1:0]   r_rptr  [4];
    logic [c_CW-1:0]   r_count [4];
    logic [1:0]        r_rr;

    logic [2:0]        r_wen;
    logic [2:0]        r_waddr [3];
    logic [15:0]       r_wdata [3];
    logic [5:0]        r_wrob  [3];

    logic [24:0]       w_head  [4];
    logic [24:0]       w_in    [4];
    logic [3:0]        w_push;
    logic [3:0]        w_gnt;
    logic [2:0]        w_port_vld;
    logic [24:0]       w_port_data [3];
    logic              w_any;
    logic [1:0]        w_last;

    for (genvar p = 0; p < 4; p++) begin : g_prod
        assign w_head[p]    = r_mem[p][r_rptr[p]];
        assign w_in[p]      = {req_waddr[3*p +: 3], req_wdata[16*p +: 16], req_wrob[6*p +: 6]};
        assign w_push[p]    = req_valid[p] && (r_count[p] != c_FULL);
        assign req_ready[p] = (r_count[p] != c_FULL) && !reset;

        always_ff @(posedge clk) begin
            if (w_push[p] && !reset && !flush) begin
                r_mem[p][r_wptr[p]] <= w_in[p];
            end
        end

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                r_wptr[p]  <= '0;
                r_rptr[p]  <= '0;
                r_count[p] <= '0;
            end else begin
                if (w_push[p]) begin
                    r_wptr[p] <= r_wptr[p] + c_PTR1;
                end
                if (w_gnt[p]) begin
                    r_rptr[p] <= r_rptr[p] + c_PTR1;
                end
                case ({w_push[p], w_gnt[p]})
                    2'b10:   r_count[p] <= r_count[p] + c_CNT1;
                    2'b01:   r_count[p] <= r_count[p] - c_CNT1;
                    default: r_count[p] <= r_count[p];
                endcase
            end
        end
    end

    // Rotating scan from r_rr; a head is skipped when its register is already
    // being written this cycle, and the scan saturates at three grants.
    always_comb begin : p_arb
        logic [3:0]  gnt;
        logic [2:0]  vld;
        logic [24:0] data [3];
        logic [1:0]  ngnt;
        logic [1:0]  last;
        logic [1:0]  idx;
        logic        conflict;

        gnt  = '0;
        vld  = '0;
        data = '{default: '0};
        ngnt = '0;
        last = r_rr;
        idx  = '0;
        conflict = 1'b0;

        for (int k = 0; k < 4; k++) begin
            idx      = r_rr + 2'(k);
            conflict = 1'b0;
            for (int j = 0; j < 3; j++) begin
                if (vld[j] && (data[j][24:22] == w_head[idx][24:22])) begin
                    conflict = 1'b1;
                end
            end
            if ((r_count[idx] != '0) && !conflict && (ngnt != 2'd3)) begin
                gnt[idx] = 1'b1;
                case (ngnt)
                    2'd0: begin vld[0] = 1'b1; data[0] = w_head[idx]; end
                    2'd1: begin vld[1] = 1'b1; data[1] = w_head[idx]; end
                    default: begin vld[2] = 1'b1; data[2] = w_head[idx]; end
                endcase
                ngnt = ngnt + 2'd1;
                last = idx;
            end
        end

        w_gnt       = gnt;
        w_port_vld  = vld;
        w_port_data = data;
        w_any       = (ngnt != 2'd0);
        w_last      = last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wen <= '0;
            r_rr  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_waddr[i] <= '0;
                r_wdata[i] <= '0;
                r_wrob[i]  <= '0;
            end
        end else if (flush) begin
            r_wen <= '0;
        end else begin
            r_wen <= w_port_vld;
            for (int i = 0; i < 3; i++) begin
                if (w_port_vld[i]) begin
                    r_waddr[i] <= w_port_data[i][24:22];
                    r_wdata[i] <= w_port_data[i][21:6];
                    r_wrob[i]  <= w_port_data[i][5:0];
                end
            end
            if (w_any) begin
                r_rr <= w_last + 2'd1;
            end
        end
    end

    assign wen0   = r_wen[0];
    assign wen1   = r_wen[1];
    assign wen2   = r_wen[2];
    assign waddr0 = r_waddr[0];
    assign waddr1 = r_waddr[1];
    assign waddr2 = r_waddr[2];
    assign wdata0 = r_wdata[0];
    assign wdata1 = r_wdata[1];
    assign wdata2 = r_wdata[2];
    assign wrob0  = r_wrob[0];
    assign wrob1  = r_wrob[1];
    assign wrob2  = r_wrob[2];

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arb
// Function : Self-checking bench for wb_port_arb against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_waddr;
    logic [63:0] req_wdata;
    logic [23:0] req_wrob;
    logic        wen0, wen1, wen2;
    logic [2:0]  waddr0, waddr1, waddr2;
    logic [15:0] wdata0, wdata1, wdata2;
    logic [5:0]  wrob0, wrob1, wrob2;

    always #5 clk = ~clk;

    wb_port_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_waddr(req_waddr), .req_wdata(req_wdata), .req_wrob(req_wrob),
        .wen0(wen0), .wen1(wen1), .wen2(wen2),
        .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .wrob0(wrob0), .wrob1(wrob1), .wrob2(wrob2)
    );

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
        logic [5:0]  r;
    } ent_t;

    ent_t q [4][$];
    int   m_rr;
    logic [2:0] ew;
    ent_t ep [3];

    int checks = 0;
    int fails  = 0;

    logic [2:0]  ow;
    logic [2:0]  oa [3];
    logic [15:0] od [3];
    logic [5:0]  orb [3];
    assign ow     = {wen2, wen1, wen0};
    assign oa[0]  = waddr0;  assign oa[1]  = waddr1;  assign oa[2]  = waddr2;
    assign od[0]  = wdata0;  assign od[1]  = wdata1;  assign od[2]  = wdata2;
    assign orb[0] = wrob0;   assign orb[1] = wrob1;   assign orb[2] = wrob2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [2:0] a, input logic [15:0] d, input logic [5:0] r);
        req_waddr[3*p +: 3]  = a;
        req_wdata[16*p +: 16] = d;
        req_wrob[6*p +: 6]   = r;
    endtask

    // Reference behaviour for one rising edge, using the inputs as sampled.
    task automatic model_edge();
        int   ng;
        int   last;
        int   p;
        bit   conflict;
        bit   full [4];
        ent_t g [3];
        int   gp [3];
        ng = 0;
        last = 0;
        if (reset) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            m_rr = 0;
            ew   = '0;
            for (int i = 0; i < 3; i++) ep[i] = '0;
        end else if (flush) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            ew = '0;
        end else begin
            for (int i = 0; i < 4; i++) full[i] = (q[i].size() >= DEPTH);
            for (int k = 0; k < 4; k++) begin
                p = (m_rr + k) % 4;
                if (ng < 3 && q[p].size() > 0) begin
                    conflict = 0;
                    for (int j = 0; j < ng; j++) if (g[j].a == q[p][0].a) conflict = 1;
                    if (!conflict) begin
                        g[ng]  = q[p][0];
                        gp[ng] = p;
                        ng++;
                        last = p;
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                ew[i] = (i < ng);
                if (i < ng) ep[i] = g[i];
            end
            for (int j = 0; j < ng; j++) void'(q[gp[j]].pop_front());
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && !full[i])
                    q[i].push_back('{a: req_waddr[3*i +: 3], d: req_wdata[16*i +: 16], r: req_wrob[6*i +: 6]});
            end
            if (ng > 0) m_rr = (last + 1) % 4;
        end
    endtask

    task automatic check_outs();
        bit dup;
        dup = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wen%0d", i), 32'(ow[i]), 32'(ew[i]));
            if (ew[i]) begin
                chk($sformatf("waddr%0d", i), 32'(oa[i]), 32'(ep[i].a));
                chk($sformatf("wdata%0d", i), 32'(od[i]), 32'(ep[i].d));
                chk($sformatf("wrob%0d", i), 32'(orb[i]), 32'(ep[i].r));
            end
        end
        for (int i = 0; i < 3; i++)
            for (int j = i + 1; j < 3; j++)
                if (ow[i] && ow[j] && oa[i] == oa[j]) dup = 1;
        chk("same_reg_pair", 32'(dup), 32'd0);
    endtask

    // Inputs are already driven (at a negedge); check ready, clock, check outputs.
    task automatic step();
        logic [3:0] er;
        #1;
        for (int i = 0; i < 4; i++) er[i] = !reset && (q[i].size() < DEPTH);
        chk("req_ready", 32'(req_ready), 32'(er));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs();
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_wen%0d", tag, i), 32'(ow[i]), 32'd0);
            chk($sformatf("%s_waddr%0d", tag, i), 32'(oa[i]), 32'd0);
            chk($sformatf("%s_wdata%0d", tag, i), 32'(od[i]), 32'd0);
            chk($sformatf("%s_wrob%0d", tag, i), 32'(orb[i]), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = '0;
        req_waddr = '0; req_wdata = '0; req_wrob = '0;
        m_rr = 0; ew = '0;
        for (int i = 0; i < 3; i++) ep[i] = '0;
        @(negedge clk);
        step();
        step();
        check_all_zero("reset");

        // Single push on p0
        reset = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 3'd3, 16'h1234, 6'd5);
        step();
        req_valid = '0;
        step();
        chk("t1_wen0", 32'(wen0), 32'd1);
        chk("t1_waddr0", 32'(waddr0), 32'd3);
        chk("t1_wdata0", 32'(wdata0), 32'h1234);
        chk("t1_wrob0", 32'(wrob0), 32'd5);
        chk("t1_wen12", 32'({wen1, wen2}), 32'd0);
        chk("t1_rr", 32'(m_rr), 32'd1);

        // Four producers, regs 1..4, from rr=0
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 4'b1111;
        for (int p = 0; p < 4; p++) set_req(p, 3'(p + 1), 16'(16'hA000 + p), 6'(20 + p));
        step();
        req_valid = '0;
        step();
        chk("t2_wen", 32'(ow), 32'h7);
        chk("t2_waddr0", 32'(waddr0), 32'd1);
        chk("t2_waddr1", 32'(waddr1), 32'd2);
        chk("t2_waddr2", 32'(waddr2), 32'd3);
        chk("t2_rr_a", 32'(m_rr), 32'd3);
        step();
        chk("t2_wen_b", 32'(ow), 32'h1);
        chk("t2_waddr0_b", 32'(waddr0), 32'd4);
        chk("t2_rr_b", 32'(m_rr), 32'd0);

        // Same-register conflict
        req_valid = 4'b0011;
        set_req(0, 3'd6, 16'h0600, 6'd10);
        set_req(1, 3'd6, 16'h0601, 6'd11);
        step();
        req_valid = '0;
        step();
        chk("t3_wen_a", 32'(ow), 32'h1);
        chk("t3_wrob0_a", 32'(wrob0), 32'd10);
        step();
        chk("t3_wen_b", 32'(ow), 32'h1);
        chk("t3_wrob0_b", 32'(wrob0), 32'd11);

        // Saturating stream: four pushers against three ports forces backpressure
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            for (int p = 0; p < 4; p++) set_req(p, 3'(p), 16'(c * 4 + p), 6'(c * 4 + p));
            step();
        end

        // Flush with traffic still presented
        flush = 1'b1;
        for (int p = 0; p < 4; p++) set_req(p, 3'(p), 16'hDEAD, 6'd63);
        step();
        chk("t5_wen", 32'(ow), 32'd0);
        flush = 1'b0;
        req_valid = '0;
        #1;
        chk("t5_ready", 32'(req_ready), 32'hF);
        @(negedge clk);
        step();
        chk("t5_wen_after", 32'(ow), 32'd0);

        // Reset together with flush during traffic
        req_valid = 4'b1111;
        for (int p = 0; p < 4; p++) set_req(p, 3'(p + 4), 16'hBEEF, 6'(p));
        step();
        step();
        reset = 1'b1; flush = 1'b1;
        step();
        check_all_zero("t6");
        chk("t6_rr", 32'(m_rr), 32'd0);
        reset = 1'b0; flush = 1'b0;

        // Randomized traffic with a small register space for frequent conflicts
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 49) == 0);
            req_valid = 4'($urandom_range(0, 15));
            for (int p = 0; p < 4; p++)
                set_req(p, 3'($urandom_range(0, 7)), 16'($urandom), 6'($urandom_range(0, 63)));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
